alarm_set_controller: RTL
=========================

# alarm_set_controller

Sequencing controller for the alarm clock's up/down modulo counters. In normal running it turns the 1 Hz tick and the counters' terminal flags into the enable cascade for seconds, minutes and hours. In set modes it routes debounced button presses as single-step or auto-repeat up/down enables to the selected clock or alarm field. It sits between the button debouncers and the counter bank, and also drives mode and blink indicators for the display mux.

## Interface
- REPEAT_DELAY, 50_000_000: cycles a single adjust button must be held before auto-repeat starts.
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeat steps once repeating.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle 1 Hz pulse.
- btn_mode  in  1  one-cycle pulse, debounced centre button.
- btn_next  in  1  one-cycle pulse, debounced right button.
- btn_prev  in  1  one-cycle pulse, debounced left button.
- btn_up  in  1  debounced level, high while held.
- btn_down  in  1  debounced level, high while held.
- sec_max  in  1  seconds counter at n-1 (59).
- min_max  in  1  clock minutes counter at n-1 (59).
- sec_en, min_en, hour_en  out  1 each  clock counter enables.
- clk_updown  out  1  direction to clock counters: 0 = up, 1 = down.
- alm_min_en, alm_hour_en  out  1 each  alarm counter enables.
- alm_updown  out  1  direction to alarm counters.
- mode  out  3  current state encoding.
- blink  out  1  display blank strobe for the selected field.

## Operation
- States and mode encoding: RUN=0, SET_CLK_MIN=1, SET_CLK_HOUR=2, SET_ALM_MIN=3, SET_ALM_HOUR=4. Codes 5–7 are unreachable; if entered, the next state is RUN.
- Mode transitions:
  - btn_mode in RUN goes to SET_CLK_MIN.
  - btn_mode in any SET state goes to RUN.
  - In SET states, btn_next steps 1→2→3→4→1 and btn_prev steps 4→3→2→1→4.
  - btn_next and btn_prev are ignored in RUN.
- Priority among button pulses: btn_mode > btn_next > btn_prev.
- Clock cascade runs in RUN, SET_ALM_MIN and SET_ALM_HOUR:
  - sec_en = tick.
  - min_en = tick & sec_max.
  - hour_en = tick & sec_max & min_max.
  - clk_updown = 0.
- In SET_CLK_MIN and SET_CLK_HOUR the clock cascade is frozen and tick is ignored for the clock counters.
- Adjust step generator:
  - Exactly one of btn_up/btn_down high; its rising edge produces one step.
  - While the same button stays held, a hold counter runs. When it reaches REPEAT_DELAY, one step is produced. After that, one step every REPEAT_PERIOD cycles until release.
  - Both buttons high, or both low: no steps, hold counter cleared.
  - A state change clears the hold counter. Auto-repeat restarts only on a new rising edge.
- Step routing:
  - SET_CLK_MIN → min_en; SET_CLK_HOUR → hour_en; SET_ALM_MIN → alm_min_en; SET_ALM_HOUR → alm_hour_en.
  - Direction output for the targeted counter group = 1 for btn_down, 0 for btn_up.
  - Steps in RUN are discarded.
  - A set step never ripples into the next field; counters wrap independently.
- alm_updown holds its last value when no alarm step is issued. Reset value is 0.
- Simultaneous events:
  - btn_mode in the same cycle as a step: the mode change wins and the step is dropped.
  - Tick and an alarm step in the same cycle in SET_ALM_*: both are issued.
- blink: 0 in RUN. In SET states it toggles on each tick and is forced to 1 for one cycle on every state change.
- Hold counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). It saturates, never wraps.

## Timing
- All outputs are registered.
- An enable appears in the cycle after the causing input is sampled (latency 1) and is high for exactly one cycle.
- sec_max and min_max are sampled in the same cycle as tick. The counters are idle between tick and the enable, so the flags are consistent.
- State change takes effect the cycle after the button pulse; mode shows the new code then.
- rst (asynchronous) forces, immediately:
  - state to RUN, mode = 0;
  - all enables, clk_updown, alm_updown and blink to 0;
  - hold counter and edge-detect registers to 0.
- A button held through reset release is not a rising edge. It produces no step until released and pressed again.

## Test plan
- Cascade:
  - RUN, tick with sec_max=1, min_max=0 → sec_en=1, min_en=1, hour_en=0 one cycle later.
  - Tick with sec_max=min_max=1 → all three enables high.
- Mode walk:
  - btn_mode → mode=1; btn_next ×4 → mode 2, 3, 4, 1.
  - btn_prev → 4; btn_mode → 0.
  - btn_next in RUN → mode stays 0.
- Single step: SET_CLK_HOUR, btn_down held for 3 cycles → exactly one hour_en with clk_updown=1; no tick-driven sec_en while in this state.
- Auto-repeat with REPEAT_DELAY=8, REPEAT_PERIOD=3: SET_ALM_MIN, btn_up held for 20 cycles → alm_min_en pulses at edge+1, +9, +12, +15, +18 relative to the press edge; alm_updown=0.
- Conflicts:
  - btn_up and btn_down both high → no enables.
  - btn_mode coinciding with a step → mode=0 and no step issued.
  - SET_ALM_HOUR tick + step in the same cycle → sec_en and alm_hour_en both high.
- Reset mid-repeat: assert rst during auto-repeat → all outputs 0 immediately; after release with btn_up still held → no steps until re-press.

Source files
------------

// File: rtl/alarm_set_controller_if.sv
// Button, counter-flag and counter-enable signals between the debouncers,
// the alarm set controller and the counter bank / display mux.
interface alarm_set_controller_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_up;
    logic       btn_down;
    logic       sec_max;
    logic       min_max;
    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic       clk_updown;
    logic       alm_min_en;
    logic       alm_hour_en;
    logic       alm_updown;
    logic [2:0] mode;
    logic       blink;

    // Stimulus side: debouncers, 1 Hz divider and counter flags.
    modport master (
        output tick, btn_mode, btn_next, btn_prev, btn_up, btn_down, sec_max, min_max,
        input  sec_en, min_en, hour_en, clk_updown, alm_min_en, alm_hour_en,
               alm_updown, mode, blink
    );

    // Controller side.
    modport slave (
        input  tick, btn_mode, btn_next, btn_prev, btn_up, btn_down, sec_max, min_max,
        output sec_en, min_en, hour_en, clk_updown, alm_min_en, alm_hour_en,
               alm_updown, mode, blink
    );
endinterface

// File: rtl/alarm_set_controller.sv
// Alarm clock sequencer: 1 Hz enable cascade in normal running, single-step and
// auto-repeat adjust enables for the selected clock/alarm field in set modes.
module alarm_set_controller #(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input logic                  clk,
    input logic                  rst,
    alarm_set_controller_if.slave bus
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_RUN          = 3'd0,
        ST_SET_CLK_MIN  = 3'd1,
        ST_SET_CLK_HOUR = 3'd2,
        ST_SET_ALM_MIN  = 3'd3,
        ST_SET_ALM_HOUR = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               state_chg_c;

    // Adjust step generator state
    logic               up_q;
    logic               down_q;
    logic               primed_q;
    logic               armed_q;
    logic               armed_d;
    logic               rep_q;
    logic               rep_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               one_hot_c;
    logic               held_c;
    logic               edge_c;
    logic               step_c;
    logic               dir_c;

    // Registered outputs and their next values
    logic sec_en_q,      sec_en_d;
    logic min_en_q,      min_en_d;
    logic hour_en_q,     hour_en_d;
    logic clk_updown_q,  clk_updown_d;
    logic alm_min_en_q,  alm_min_en_d;
    logic alm_hour_en_q, alm_hour_en_d;
    logic alm_updown_q,  alm_updown_d;
    logic blink_q,       blink_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: btn_mode beats btn_next beats btn_prev
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.btn_mode) state_d = ST_SET_CLK_MIN;
            end
            ST_SET_CLK_MIN: begin
                if (bus.btn_mode)      state_d = ST_RUN;
                else if (bus.btn_next) state_d = ST_SET_CLK_HOUR;
                else if (bus.btn_prev) state_d = ST_SET_ALM_HOUR;
            end
            ST_SET_CLK_HOUR: begin
                if (bus.btn_mode)      state_d = ST_RUN;
                else if (bus.btn_next) state_d = ST_SET_ALM_MIN;
                else if (bus.btn_prev) state_d = ST_SET_CLK_MIN;
            end
            ST_SET_ALM_MIN: begin
                if (bus.btn_mode)      state_d = ST_RUN;
                else if (bus.btn_next) state_d = ST_SET_ALM_HOUR;
                else if (bus.btn_prev) state_d = ST_SET_CLK_HOUR;
            end
            ST_SET_ALM_HOUR: begin
                if (bus.btn_mode)      state_d = ST_RUN;
                else if (bus.btn_next) state_d = ST_SET_CLK_MIN;
                else if (bus.btn_prev) state_d = ST_SET_ALM_MIN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign state_chg_c = (state_d != state_q);

    // Edge detection; primed_q masks a button already held when reset is released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            primed_q <= 1'b0;
            armed_q  <= 1'b0;
            rep_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            up_q     <= bus.btn_up;
            down_q   <= bus.btn_down;
            primed_q <= 1'b1;
            armed_q  <= armed_d;
            rep_q    <= rep_d;
            cnt_q    <= cnt_d;
        end
    end

    assign one_hot_c = bus.btn_up ^ bus.btn_down;
    assign held_c    = one_hot_c & ((bus.btn_up & up_q) | (bus.btn_down & down_q));
    assign edge_c    = primed_q & one_hot_c &
                       ((bus.btn_up & ~up_q) | (bus.btn_down & ~down_q));
    assign dir_c     = bus.btn_down;

    // Hold counter: first step on the edge, one after REPEAT_DELAY, then every REPEAT_PERIOD
    always_comb begin
        armed_d = armed_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        step_c  = 1'b0;
        if (state_chg_c || !one_hot_c) begin
            armed_d = 1'b0;
            rep_d   = 1'b0;
            cnt_d   = '0;
        end else if (edge_c) begin
            step_c  = 1'b1;
            armed_d = 1'b1;
            rep_d   = 1'b0;
            cnt_d   = CNT_W'(1);
        end else if (armed_q && held_c) begin
            if ((!rep_q && cnt_q == CNT_W'(REPEAT_DELAY)) ||
                ( rep_q && cnt_q == CNT_W'(REPEAT_PERIOD))) begin
                step_c = 1'b1;
                rep_d  = 1'b1;
                cnt_d  = CNT_W'(1);
            end else if (cnt_q != CNT_W'(CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            armed_d = 1'b0;
            rep_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    // Output decode: tick cascade where the clock runs, step routing by selected field
    always_comb begin
        sec_en_d      = 1'b0;
        min_en_d      = 1'b0;
        hour_en_d     = 1'b0;
        clk_updown_d  = clk_updown_q;
        alm_min_en_d  = 1'b0;
        alm_hour_en_d = 1'b0;
        alm_updown_d  = alm_updown_q;
        blink_d       = blink_q;
        case (state_q)
            ST_SET_CLK_MIN: begin
                min_en_d = step_c;
                if (step_c) clk_updown_d = dir_c;
            end
            ST_SET_CLK_HOUR: begin
                hour_en_d = step_c;
                if (step_c) clk_updown_d = dir_c;
            end
            default: begin
                sec_en_d     = bus.tick;
                min_en_d     = bus.tick & bus.sec_max;
                hour_en_d    = bus.tick & bus.sec_max & bus.min_max;
                clk_updown_d = 1'b0;
                if (state_q == ST_SET_ALM_MIN) begin
                    alm_min_en_d = step_c;
                    if (step_c) alm_updown_d = dir_c;
                end else if (state_q == ST_SET_ALM_HOUR) begin
                    alm_hour_en_d = step_c;
                    if (step_c) alm_updown_d = dir_c;
                end
            end
        endcase
        if (state_d == ST_RUN) begin
            blink_d = 1'b0;
        end else if (state_chg_c) begin
            blink_d = 1'b1;
        end else if (bus.tick) begin
            blink_d = ~blink_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_en_q      <= 1'b0;
            min_en_q      <= 1'b0;
            hour_en_q     <= 1'b0;
            clk_updown_q  <= 1'b0;
            alm_min_en_q  <= 1'b0;
            alm_hour_en_q <= 1'b0;
            alm_updown_q  <= 1'b0;
            blink_q       <= 1'b0;
        end else begin
            sec_en_q      <= sec_en_d;
            min_en_q      <= min_en_d;
            hour_en_q     <= hour_en_d;
            clk_updown_q  <= clk_updown_d;
            alm_min_en_q  <= alm_min_en_d;
            alm_hour_en_q <= alm_hour_en_d;
            alm_updown_q  <= alm_updown_d;
            blink_q       <= blink_d;
        end
    end

    assign bus.sec_en      = sec_en_q;
    assign bus.min_en      = min_en_q;
    assign bus.hour_en     = hour_en_q;
    assign bus.clk_updown  = clk_updown_q;
    assign bus.alm_min_en  = alm_min_en_q;
    assign bus.alm_hour_en = alm_hour_en_q;
    assign bus.alm_updown  = alm_updown_q;
    assign bus.mode        = state_q;
    assign bus.blink       = blink_q;

endmodule
